fadd_arbiter: RTL

FADD_ARBITER -- requirements
Module: fadd_arbiter

---
 rtl/fadd_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter that shares one combinational f32 adder among NREQ
// requesters. A transfer registers the winning operands onto the adder
// inputs; the adder result is carried down a fixed-latency pipeline with
// its requester id and returned as a one-cycle pulse exactly LAT cycles
// after acceptance. Grants are only issued while the controller is in RUN.
module fadd_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    input  logic [31:0]          add_sum,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_sum,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LAT + 1);
    localparam int NS = LAT - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic            tag_valid;
    logic [PW-1:0]   tag_id;
    logic            stg_valid [NS];
    logic [PW-1:0]   stg_id    [NS];
    logic [31:0]     stg_data  [NS];
    logic [31:0]     a_word    [NREQ];
    logic [31:0]     b_word    [NREQ];
    logic [PW:0]     cand;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic            grant_ok;
    logic            transfer;
    logic            retire;
    logic [NREQ-1:0] rsp_onehot;

    // Unpack the flat operand buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_word[i] = req_a[32*i +: 32];
            b_word[i] = req_b[32*i +: 32];
        end
    end

    // Round-robin search: first valid requester at or above ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (PW+1)'(ptr) + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    // Grant is one-hot and only offered while running with enable high.
    always_comb begin
        grant_ok  = en && (state == RUN);
        req_ready = '0;
        if (grant_ok && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
        transfer = |(req_valid & req_ready);
        retire   = stg_valid[NS-1];
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Controller transitions, driven by enable, pending requests and in-flight count.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (en && (|req_valid)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = (count == '0) ? IDLE : DRAIN;
                end else if (!(|req_valid) && (count == '0)) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (en) begin
                    state_next = RUN;
                end else if (count == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointer moves past the winner on every transfer so each requester gets a turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Adder operand registers and their tag; operands persist until the next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a     <= '0;
            add_b     <= '0;
            tag_valid <= 1'b0;
            tag_id    <= '0;
        end else begin
            tag_valid <= transfer;
            if (transfer) begin
                add_a  <= a_word[grant_idx];
                add_b  <= b_word[grant_idx];
                tag_id <= grant_idx;
            end
        end
    end

    // Result pipeline: captures the adder output one cycle after acceptance and shifts it along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NS; s++) begin
                stg_valid[s] <= 1'b0;
                stg_id[s]    <= '0;
                stg_data[s]  <= '0;
            end
        end else begin
            stg_valid[0] <= tag_valid;
            stg_id[0]    <= tag_id;
            stg_data[0]  <= add_sum;
            for (int s = 1; s < NS; s++) begin
                stg_valid[s] <= stg_valid[s-1];
                stg_id[s]    <= stg_id[s-1];
                stg_data[s]  <= stg_data[s-1];
            end
        end
    end

    // Decode the id at the end of the pipeline into a per-requester pulse.
    always_comb begin
        rsp_onehot = '0;
        rsp_onehot[stg_id[NS-1]] = 1'b1;
    end

    // Response register; data is forced to zero whenever no pulse is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_sum   <= '0;
        end else begin
            rsp_valid <= retire ? rsp_onehot : '0;
            rsp_sum   <= retire ? stg_data[NS-1] : '0;
        end
    end

    // In-flight counter: up on transfer, down when a response is issued, both cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({transfer, retire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign busy = (count != '0);

endmodule
